hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It sequences fetch and decode stalls for load-use hazards and pipeline flushes for taken branches, JAL and JALR. It also generates all forwarding selects: the E-stage ALU operand muxes, and the decode-stage writeback bypass that feeds ForwardAEDec/ForwardBEDec. Stall and redirect sequencing is held in a small FSM with bubble counters, so memory and fetch latency can be tuned.

---
 rtl/hazard_ctrl_if.sv | 55 +++++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with hazard_ctrl.
// HAZARD_PERF_CNT_EN adds perf_clr and the two performance counters.
interface hazard_ctrl_if;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic       uses_rs2_d;
  logic [4:0] rs1_e;
  logic [4:0] rs2_e;
  logic [4:0] rd_e;
  logic       regwrite_e;
  logic       load_e;
  logic [4:0] rd_m;
  logic       regwrite_m;
  logic [4:0] rd_w;
  logic       regwrite_w;
  logic       branch_taken_e;
  logic       jal_e;
  logic       jalr_e;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] forward_a_e;
  logic [1:0] forward_b_e;
  logic [1:0] forward_a_dec;
  logic [1:0] forward_b_dec;
  logic       busy;
`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  modport master (
    output rs1_d, rs2_d, uses_rs2_d, rs1_e, rs2_e, rd_e, regwrite_e, load_e,
    output rd_m, regwrite_m, rd_w, regwrite_w, branch_taken_e, jal_e, jalr_e,
`ifdef HAZARD_PERF_CNT_EN
    output perf_clr,
    input  stall_cycles, flush_events,
`endif
    input  stall_f, stall_d, flush_d, flush_e, busy,
    input  forward_a_e, forward_b_e, forward_a_dec, forward_b_dec
  );

  modport slave (
    input  rs1_d, rs2_d, uses_rs2_d, rs1_e, rs2_e, rd_e, regwrite_e, load_e,
    input  rd_m, regwrite_m, rd_w, regwrite_w, branch_taken_e, jal_e, jalr_e,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_clr,
    output stall_cycles, flush_events,
`endif
    output stall_f, stall_d, flush_d, flush_e, busy,
    output forward_a_e, forward_b_e, forward_a_dec, forward_b_dec
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage hazard controller: load-use stalls, redirect flushes, forwarding selects.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALLS      = 1,
  parameter int unsigned REDIRECT_BUBBLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  hazard_ctrl_if.slave    hz
);

  typedef enum logic [1:0] {StRun, StLdStall, StRedir} state_e;

  localparam logic [2:0] LdCnt    = 3'(LOAD_STALLS - 1);
  localparam logic [2:0] RedirCnt = 3'(REDIRECT_BUBBLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stall_c, flush_d_c, flush_e_c;
  logic       redirect, lu_hazard;

  assign redirect  = hz.branch_taken_e | hz.jal_e | hz.jalr_e;
  assign lu_hazard = hz.load_e && hz.regwrite_e && (hz.rd_e != 5'd0) &&
                     ((hz.rd_e == hz.rs1_d) || (hz.uses_rs2_d && (hz.rd_e == hz.rs2_d)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    unique case (state_q)
      StRun, StLdStall: begin
        if (redirect) begin
          // Redirect beats any load-use stall, including one already in progress.
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            state_d = StRedir;
            cnt_d   = RedirCnt;
          end else begin
            state_d = StRun;
            cnt_d   = 3'd0;
          end
        end else if (state_q == StLdStall) begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          cnt_d     = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = StRun;
        end else if (lu_hazard) begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          if (LOAD_STALLS > 1) begin
            state_d = StLdStall;
            cnt_d   = LdCnt;
          end
        end
      end
      StRedir: begin
        flush_d_c = 1'b1;
        if (redirect) begin
          flush_e_c = 1'b1;
          cnt_d     = RedirCnt;
        end else if (cnt_q == 3'd1) begin
          state_d = StRun;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  function automatic logic [1:0] fwd_e(input logic [4:0] rs, input logic wm, input logic [4:0] rdm,
                                       input logic ww, input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  logic wb_hit_a, wb_hit_b;
  assign wb_hit_a = hz.regwrite_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_d);
  assign wb_hit_b = hz.regwrite_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_d);

  // Every output is forced low while reset is held, including the combinational paths.
  assign hz.stall_f       = rst & stall_c;
  assign hz.stall_d       = rst & stall_c;
  assign hz.flush_d       = rst & flush_d_c;
  assign hz.flush_e       = rst & flush_e_c;
  assign hz.busy          = rst & (state_q != StRun);
  assign hz.forward_a_e   = {2{rst}} & fwd_e(hz.rs1_e, hz.regwrite_m, hz.rd_m,
                                             hz.regwrite_w, hz.rd_w);
  assign hz.forward_b_e   = {2{rst}} & fwd_e(hz.rs2_e, hz.regwrite_m, hz.rd_m,
                                             hz.regwrite_w, hz.rd_w);
  assign hz.forward_a_dec = {1'b0, rst & wb_hit_a};
  assign hz.forward_b_dec = {1'b0, rst & wb_hit_b};

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (hz.perf_clr) begin
      stall_cycles_d = 32'd0;
      flush_events_d = 32'd0;
    end else begin
      if (stall_c && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
      if (redirect && (flush_events_q != 32'hFFFF_FFFF)) flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two parameterisations driven with identical stimulus
// and compared every cycle against a remaining-cycles reference model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
  logic uses_rs2_d = 0, regwrite_e = 0, load_e = 0, regwrite_m = 0, regwrite_w = 0;
  logic branch_taken_e = 0, jal_e = 0, jalr_e = 0;

  hazard_ctrl_if hz0 ();
  hazard_ctrl_if hz1 ();

  assign hz0.rs1_d = rs1_d;           assign hz1.rs1_d = rs1_d;
  assign hz0.rs2_d = rs2_d;           assign hz1.rs2_d = rs2_d;
  assign hz0.uses_rs2_d = uses_rs2_d; assign hz1.uses_rs2_d = uses_rs2_d;
  assign hz0.rs1_e = rs1_e;           assign hz1.rs1_e = rs1_e;
  assign hz0.rs2_e = rs2_e;           assign hz1.rs2_e = rs2_e;
  assign hz0.rd_e = rd_e;             assign hz1.rd_e = rd_e;
  assign hz0.regwrite_e = regwrite_e; assign hz1.regwrite_e = regwrite_e;
  assign hz0.load_e = load_e;         assign hz1.load_e = load_e;
  assign hz0.rd_m = rd_m;             assign hz1.rd_m = rd_m;
  assign hz0.regwrite_m = regwrite_m; assign hz1.regwrite_m = regwrite_m;
  assign hz0.rd_w = rd_w;             assign hz1.rd_w = rd_w;
  assign hz0.regwrite_w = regwrite_w; assign hz1.regwrite_w = regwrite_w;
  assign hz0.branch_taken_e = branch_taken_e; assign hz1.branch_taken_e = branch_taken_e;
  assign hz0.jal_e = jal_e;           assign hz1.jal_e = jal_e;
  assign hz0.jalr_e = jalr_e;         assign hz1.jalr_e = jalr_e;
`ifdef HAZARD_PERF_CNT_EN
  assign hz0.perf_clr = 1'b0;         assign hz1.perf_clr = 1'b0;
`endif

  hazard_ctrl #(.LOAD_STALLS(1), .REDIRECT_BUBBLES(2)) u_dut0 (.clk(clk), .rst(rst), .hz(hz0));
  hazard_ctrl #(.LOAD_STALLS(3), .REDIRECT_BUBBLES(3)) u_dut1 (.clk(clk), .rst(rst), .hz(hz1));

  // {stall_f, stall_d, flush_d, flush_e, busy}
  logic [4:0] act_ctrl [2];
  logic [7:0] act_fwd  [2];
  assign act_ctrl[0] = {hz0.stall_f, hz0.stall_d, hz0.flush_d, hz0.flush_e, hz0.busy};
  assign act_ctrl[1] = {hz1.stall_f, hz1.stall_d, hz1.flush_d, hz1.flush_e, hz1.busy};
  assign act_fwd[0]  = {hz0.forward_a_e, hz0.forward_b_e, hz0.forward_a_dec, hz0.forward_b_dec};
  assign act_fwd[1]  = {hz1.forward_a_e, hz1.forward_b_e, hz1.forward_a_dec, hz1.forward_b_dec};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: remaining stall cycles and remaining redirect flush cycles per DUT.
  int ls [2] = '{1, 3};
  int rb [2] = '{2, 3};
  int ld_rem [2] = '{0, 0};
  int rd_rem [2] = '{0, 0};

  function automatic logic redirect_m();
    return branch_taken_e | jal_e | jalr_e;
  endfunction

  function automatic logic lu_m();
    return load_e && regwrite_e && rd_e != 0 && (rd_e == rs1_d || (uses_rs2_d && rd_e == rs2_d));
  endfunction

  function automatic logic [4:0] exp_ctrl(input int i);
    logic sf = 0, fd = 0, fe = 0, b;
    if (!rst) return 5'b0;
    b = (ld_rem[i] > 0) || (rd_rem[i] > 0);
    if (redirect_m()) begin fd = 1; fe = 1; end
    else if (rd_rem[i] > 0) fd = 1;
    else if (ld_rem[i] > 0 || lu_m()) begin sf = 1; fe = 1; end
    return {sf, sf, fd, fe, b};
  endfunction

  function automatic logic [1:0] fe_m(input logic [4:0] rs);
    if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] fd_m(input logic [4:0] rs);
    return (regwrite_w && rd_w != 0 && rd_w == rs) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [7:0] exp_fwd();
    if (!rst) return 8'h0;
    return {fe_m(rs1_e), fe_m(rs2_e), fd_m(rs1_d), fd_m(rs2_d)};
  endfunction

`ifdef HAZARD_PERF_CNT_EN
  int unsigned perf_stall [2] = '{0, 0};
  int unsigned perf_flush [2] = '{0, 0};
`endif

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        ld_rem[i] = 0;
        rd_rem[i] = 0;
`ifdef HAZARD_PERF_CNT_EN
        perf_stall[i] = 0;
        perf_flush[i] = 0;
`endif
      end else begin
`ifdef HAZARD_PERF_CNT_EN
        if (exp_ctrl(i)[3]) perf_stall[i]++;
        if (redirect_m()) perf_flush[i]++;
`endif
        if (redirect_m()) begin
          rd_rem[i] = rb[i] - 1;
          ld_rem[i] = 0;
        end else if (rd_rem[i] > 0) rd_rem[i]--;
        else if (ld_rem[i] > 0) ld_rem[i]--;
        else if (lu_m()) ld_rem[i] = ls[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ctrl%0d", i), 32'(act_ctrl[i]), 32'(exp_ctrl(i)));
      check($sformatf("fwd%0d", i), 32'(act_fwd[i]), 32'(exp_fwd()));
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("perf_stall%0d", i), i == 0 ? hz0.stall_cycles : hz1.stall_cycles,
            perf_stall[i]);
      check($sformatf("perf_flush%0d", i), i == 0 ? hz0.flush_events : hz1.flush_events,
            perf_flush[i]);
`endif
    end
  end

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {uses_rs2_d, regwrite_e, load_e, regwrite_m, regwrite_w} = '0;
    {branch_taken_e, jal_e, jalr_e} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset: forwarding-capable inputs present, yet every output must be low.
    regwrite_m = 1; rd_m = 7; rs1_e = 7; regwrite_w = 1; rd_w = 9; rs2_d = 9;
    #2;
    check("rst_ctrl0", 32'(act_ctrl[0]), 32'h0);
    check("rst_fwd0", 32'(act_fwd[0]), 32'h0);
    check("rst_ctrl1", 32'(act_ctrl[1]), 32'h0);
    next_cycle(); next_cycle();
    rst = 1;
    clear_inputs();
    next_cycle();

    // Load-use hazard on rs1.
    load_e = 1; regwrite_e = 1; rd_e = 5; rs1_d = 5;
    at_neg();
    check("lu_first0", 32'(act_ctrl[0]), 32'b11010);
    check("lu_first1", 32'(act_ctrl[1]), 32'b11010);
    next_cycle();
    load_e = 0;
    at_neg();
    check("lu_after0", 32'(act_ctrl[0]), 32'b00000);
    check("lu_c2_1", 32'(act_ctrl[1]), 32'b11011);
    next_cycle();
    at_neg();
    check("lu_c3_1", 32'(act_ctrl[1]), 32'b11011);
    next_cycle();
    at_neg();
    check("lu_done1", 32'(act_ctrl[1]), 32'b00000);
    next_cycle();

    // Taken branch coinciding with a load-use hazard.
    branch_taken_e = 1; load_e = 1; regwrite_e = 1; rd_e = 5; rs1_d = 5;
    at_neg();
    check("br_first0", 32'(act_ctrl[0]), 32'b00110);
    next_cycle();
    clear_inputs();
    at_neg();
    check("br_second0", 32'(act_ctrl[0]), 32'b00101);
    check("br_second1", 32'(act_ctrl[1]), 32'b00101);
    next_cycle();
    at_neg();
    check("br_done0", 32'(act_ctrl[0]), 32'b00000);
    check("br_third1", 32'(act_ctrl[1]), 32'b00101);
    next_cycle();

    // Forwarding priorities and x0.
    rd_m = 7; rd_w = 7; regwrite_m = 1; regwrite_w = 1; rs1_e = 7;
    #1 check("fwd_m", 32'(hz0.forward_a_e), 32'b10);
    regwrite_m = 0;
    #1 check("fwd_w", 32'(hz0.forward_a_e), 32'b01);
    rd_m = 0; rd_w = 0; regwrite_m = 1; rs1_e = 0;
    #1 check("fwd_x0", 32'(hz0.forward_a_e), 32'b00);
    rd_w = 9; regwrite_w = 1; rs2_d = 9;
    #1 check("fwd_bdec", 32'(hz0.forward_b_dec), 32'b01);

    // No stall for x0 destination or unused rs2.
    clear_inputs();
    load_e = 1; regwrite_e = 1; rd_e = 0; rs1_d = 0;
    #1 check("nostall_x0", 32'(act_ctrl[0]), 32'b0);
    rd_e = 4; rs1_d = 3; rs2_d = 4; uses_rs2_d = 0;
    #1 check("nostall_rs2", 32'(act_ctrl[1]), 32'b0);
    next_cycle();

    // Reset during the second LDSTALL cycle.
    clear_inputs();
    load_e = 1; regwrite_e = 1; rd_e = 5; rs1_d = 5; regwrite_m = 1; rd_m = 3; rs1_e = 3;
    next_cycle();
    #1 rst = 0;
    #1;
    check("midrst_ctrl1", 32'(act_ctrl[1]), 32'b0);
    check("midrst_fwd1", 32'(act_fwd[1]), 32'b0);
    next_cycle();
    clear_inputs();
    rst = 1;
    at_neg();
    check("midrst_busy1", 32'(hz1.busy), 32'b0);
    next_cycle();

    // Randomized traffic with small register numbers so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3));  rd_m = 5'($urandom_range(0, 3));
      rd_w = 5'($urandom_range(0, 3));
      uses_rs2_d = 1'($urandom); regwrite_e = 1'($urandom); load_e = 1'($urandom);
      regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
      branch_taken_e = ($urandom_range(0, 9) == 0);
      jal_e = ($urandom_range(0, 19) == 0);
      jalr_e = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 0;
        next_cycle();
        rst = 1;
      end else begin
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
